// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared encodings for the branch redirect controller: jump types, CCR flag
// positions and FSM states.
package branch_pkg;

  localparam logic [1:0] JT_Z      = 2'b00;
  localparam logic [1:0] JT_N      = 2'b01;
  localparam logic [1:0] JT_C      = 2'b10;
  localparam logic [1:0] JT_ALWAYS = 2'b11;

  localparam int CCR_Z = 0;
  localparam int CCR_N = 1;
  localparam int CCR_C = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } br_state_e;

endpackage

// File: rtl/branch_redirect_ctrl_cond_eval.sv
// Combinational branch condition evaluation: decides whether the EX branch is
// taken and which CCR flag it consumes (one-hot, zero for unconditional).
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic       ex_branch,
  input  logic [1:0] ex_jmp_type,
  input  logic [3:0] ccr,
  output logic       taken,
  output logic [3:0] clr_onehot
);

  // The V flag is carried on the bus but no jump type tests it.
  logic unused_ccr_v;
  assign unused_ccr_v = ccr[3];

  always_comb begin
    taken      = 1'b0;
    clr_onehot = '0;
    if (ex_branch) begin
      case (ex_jmp_type)
        JT_Z: if (ccr[CCR_Z]) begin
          taken             = 1'b1;
          clr_onehot[CCR_Z] = 1'b1;
        end
        JT_N: if (ccr[CCR_N]) begin
          taken             = 1'b1;
          clr_onehot[CCR_N] = 1'b1;
        end
        JT_C: if (ccr[CCR_C]) begin
          taken             = 1'b1;
          clr_onehot[CCR_C] = 1'b1;
        end
        default: taken = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// PC redirect and pipeline flush sequencer for branches resolved in EX.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_redirect_ctrl
  import branch_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_branch,
  input  logic [1:0]        ex_jmp_type,
  input  logic [3:0]        ccr,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              stall,
  output logic              pc_sel,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic [3:0]        ccr_clr,
  output logic              busy
`ifdef BRANCH_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  taken_cnt
`endif
);

  generate
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
      $error("branch_redirect_ctrl: FLUSH_CYCLES must be within 1..7");
    end
  endgenerate

  localparam logic [2:0] FC = 3'(FLUSH_CYCLES);

  br_state_e  state;
  logic [2:0] flush_cnt;
  logic [2:0] flush_cnt_nxt;
  logic       taken;
  logic [3:0] clr_onehot;
  logic       sample;

  branch_cond_eval u_cond_eval (
    .ex_branch  (ex_branch),
    .ex_jmp_type(ex_jmp_type),
    .ccr        (ccr),
    .taken      (taken),
    .clr_onehot (clr_onehot)
  );

  assign sample        = (state == IDLE) && !stall;
  assign flush_cnt_nxt = flush_cnt + 3'd1;

  // The REDIRECT cycle is the first flush cycle; FLUSH supplies the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc_sel     <= 1'b0;
      pc_target  <= '0;
      flush_ifid <= 1'b0;
      flush_idex <= 1'b0;
      ccr_clr    <= '0;
      busy       <= 1'b0;
      flush_cnt  <= '0;
    end else begin
      ccr_clr <= '0;
      case (state)
        IDLE: begin
          if (sample && taken) begin
            state      <= REDIRECT;
            pc_sel     <= 1'b1;
            pc_target  <= ex_target;
            flush_ifid <= 1'b1;
            flush_idex <= 1'b1;
            ccr_clr    <= clr_onehot;
            busy       <= 1'b1;
            flush_cnt  <= '0;
          end
        end
        REDIRECT: begin
          if (!stall) begin
            pc_sel <= 1'b0;
            if (FC == 3'd1) begin
              state      <= IDLE;
              flush_ifid <= 1'b0;
              flush_idex <= 1'b0;
              busy       <= 1'b0;
            end else begin
              state     <= FLUSH;
              flush_cnt <= 3'd1;
            end
          end
        end
        FLUSH: begin
          if (!stall) begin
            if (flush_cnt_nxt == FC) begin
              state      <= IDLE;
              flush_ifid <= 1'b0;
              flush_idex <= 1'b0;
              busy       <= 1'b0;
              flush_cnt  <= '0;
            end else begin
              flush_cnt <= flush_cnt_nxt;
            end
          end
        end
        default: begin
          state      <= IDLE;
          pc_sel     <= 1'b0;
          flush_ifid <= 1'b0;
          flush_idex <= 1'b0;
          busy       <= 1'b0;
          flush_cnt  <= '0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else if (stats_clr) begin
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else if (sample && ex_branch) begin
      br_cnt <= sat_inc(br_cnt);
      if (taken) taken_cnt <= sat_inc(taken_cnt);
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
